// File: rtl/scan_wr_arbiter.sv
// Round-robin scheduler sharing the CCI-P c1 write channel among NUM_REQ scan result producers.
// Define SCAN_WR_ARB_STATS_EN to build the stall_cycles counter; otherwise it is tied to 0.
module scan_wr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 42,
  parameter int DATA_W  = 512,
  parameter int MAX_OUT = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cfg_start,
  input  logic [ADDR_W-1:0]         cfg_base,
  input  logic [15:0]               cfg_lines,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      c1_alm_full,
  input  logic                      wr_rsp,
  output logic                      wr_valid,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic [15:0]               wr_mdata,
  output logic                      busy,
  output logic                      done,
  output logic [6:0]                outstanding,
  output logic [31:0]               stall_cycles
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW    = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q;
  logic [15:0]         lines_q;
  logic [15:0]         line_cnt_q [NUM_REQ];
  logic [PTR_W-1:0]    rr_q, rr_d;
  logic [6:0]          out_q, out_d;
  logic                wr_valid_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic [15:0]         wr_mdata_q;

  logic                start_ok, room, xfer, all_full, ack_take;
  logic [PTR_W-1:0]    gnt_id, idx_c;
  logic [SW-1:0]       sum_c;
  logic [NUM_REQ-1:0]  gnt;

  assign start_ok = cfg_start && ((state_q == IDLE) || (state_q == DONE));
  // No grant while reset is asserted: the line would be lost when the block clears.
  assign room     = reset_n && (state_q == RUN) && !c1_alm_full && (out_q < 7'(MAX_OUT));

  always_comb begin
    gnt    = '0;
    xfer   = 1'b0;
    gnt_id = '0;
    sum_c  = '0;
    idx_c  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_c = {1'b0, rr_q} + SW'(k);
      if (sum_c >= SW'(NUM_REQ)) sum_c = sum_c - SW'(NUM_REQ);
      idx_c = sum_c[PTR_W-1:0];
      if (!xfer && room && req_valid[idx_c] && (line_cnt_q[idx_c] < lines_q)) begin
        xfer   = 1'b1;
        gnt_id = idx_c;
      end
    end
    if (xfer) gnt[gnt_id] = 1'b1;
  end

  always_comb begin
    all_full = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (line_cnt_q[i] != lines_q) all_full = 1'b0;
    end
  end

  assign rr_d     = (gnt_id == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_id + PTR_W'(1);
  assign ack_take = wr_rsp && (out_q != 7'd0);
  assign out_d    = out_q + 7'(xfer) - 7'(ack_take);

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      RUN:     if (all_full) state_d = DRAIN;
      DRAIN:   if (out_d == 7'd0) state_d = DONE;
      DONE:    if (start_ok) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      base_q     <= '0;
      lines_q    <= '0;
      rr_q       <= '0;
      out_q      <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_mdata_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) line_cnt_q[i] <= '0;
    end else begin
      out_q      <= out_d;
      wr_valid_q <= xfer;
      if (start_ok) begin
        base_q  <= cfg_base;
        lines_q <= cfg_lines;
        rr_q    <= '0;
        for (int i = 0; i < NUM_REQ; i++) line_cnt_q[i] <= '0;
      end else if (xfer) begin
        // Region base is base + id*lines at full address width, then the line offset.
        wr_addr_q  <= base_q + ADDR_W'(gnt_id) * ADDR_W'(lines_q) + ADDR_W'(line_cnt_q[gnt_id]);
        wr_data_q  <= req_data[int'(gnt_id)*DATA_W +: DATA_W];
        wr_mdata_q <= {8'(gnt_id), line_cnt_q[gnt_id][7:0]};
        line_cnt_q[gnt_id] <= line_cnt_q[gnt_id] + 16'd1;
        rr_q       <= rr_d;
      end
    end
  end

`ifdef SCAN_WR_ARB_STATS_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else if (start_ok) begin
      stall_q <= '0;
    end else if ((state_q == RUN) && (|req_valid) && !xfer && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

  assign req_ready   = gnt;
  assign wr_valid    = wr_valid_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign wr_mdata    = wr_mdata_q;
  assign outstanding = out_q;
  assign busy        = (state_q == RUN) || (state_q == DRAIN);
  assign done        = (state_q == DONE);

endmodule

// File: doc/scan_wr_arbiter.md
# scan_wr_arbiter

Round-robin scheduler that shares the single CCI-P c1 write channel between NUM_REQ filter-scan result producers. Each producer's 512-bit result lines go to its own contiguous region of the host result buffer. The block owns the per-producer address counters, throttles on c1TxAlmFull and on an outstanding-write limit, counts write acknowledgements, and raises done once every region is written and acknowledged. It sits between the filter-scan instances and the af2cp_sTx.c1 request register in app_afu_cci.

## Interface
Parameters:
- NUM_REQ, 4: number of result producers (2..8).
- ADDR_W, 42: cache-line address width (t_ccip_clAddr).
- DATA_W, 512: line width.
- MAX_OUT, 16: maximum un-acked writes in flight (power of two, at most 64).

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- cfg_start  in  1  one-cycle pulse; latches cfg_base and cfg_lines.
- cfg_base  in  ADDR_W  cache-line address of region 0.
- cfg_lines  in  16  lines per producer region; region i base = cfg_base + i*cfg_lines.
- req_valid  in  NUM_REQ  producer i has a result line.
- req_data  in  NUM_REQ*DATA_W  producer i's line occupies slice [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot grant; a line transfers when valid&ready.
- c1_alm_full  in  1  cp2af_sRx.c1TxAlmFull.
- wr_rsp  in  1  one write acknowledgement (c1 rspValid, unpacked).
- wr_valid  out  1  write request valid.
- wr_addr  out  ADDR_W  write request line address.
- wr_data  out  DATA_W  write request data.
- wr_mdata  out  16  {8'(producer id), 8'(line index[7:0])}.
- busy  out  1  state is RUN or DRAIN.
- done  out  1  state is DONE.
- outstanding  out  7  current un-acked write count.
- stall_cycles  out  32  statistics counter (see Configuration).

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset puts the block in IDLE.
- IDLE or DONE, with cfg_start: latch cfg_base and cfg_lines, clear all per-producer line counters and the round-robin pointer, go to RUN.
- cfg_start in RUN or DRAIN is ignored.
- Eligibility in RUN: producer i is eligible when req_valid[i], line_cnt[i] < cfg_lines, !c1_alm_full, and outstanding < MAX_OUT.
- Grant: the first eligible producer at or after rr_ptr, wrapping modulo NUM_REQ.
- After a grant, rr_ptr = (granted id + 1) mod NUM_REQ. rr_ptr is unchanged when nothing is granted.
- req_ready is combinational from the registered state and the inputs. At most one bit is high, and never outside RUN.
- On transfer from producer i:
  - register wr_valid=1;
  - wr_addr = cfg_base + i*cfg_lines + line_cnt[i], computed modulo 2^ADDR_W;
  - wr_data = producer i's slice;
  - wr_mdata = {i, line_cnt[i][7:0]};
  - line_cnt[i] increments.
- The product i*cfg_lines is computed at full width (ADDR_W), with no truncation to 16 bits.
- Outstanding counter:
  - +1 on transfer, -1 on wr_rsp, unchanged when both happen in the same cycle.
  - wr_rsp arriving with outstanding == 0 is dropped; the counter saturates at 0.
- RUN to DRAIN: every line_cnt[i] == cfg_lines.
- DRAIN to DONE: outstanding == 0, counting the current cycle's wr_rsp.
- cfg_lines == 0: RUN goes to DRAIN on the first RUN cycle, then DONE the next cycle if outstanding == 0.
- done holds until the next cfg_start or reset.

## Timing
- Request latency: a transfer in cycle N gives wr_valid=1 in cycle N+1 with the matching addr, data and mdata. wr_valid is high for exactly one cycle per transfer.
- Back-to-back transfers yield back-to-back wr_valid, one line per cycle maximum.
- c1_alm_full is sampled combinationally. When it is high in cycle N, there is no transfer in N and no wr_valid in N+1.
- outstanding reflects transfers and acks of the previous cycle. The MAX_OUT check uses the registered value, so the count never exceeds MAX_OUT.
- done and busy are registered state decodes.
- Reset values, all outputs:
  - wr_valid=0, req_ready=0, busy=0, done=0, outstanding=0, stall_cycles=0;
  - wr_addr, wr_data, wr_mdata = 0.
- Reset mid-operation: reset_n low in any state returns the block to IDLE on the next edge. Counters and rr_ptr clear, and any in-flight ack count is discarded.

## Configuration
- SCAN_WR_ARB_STATS_EN defined:
  - stall_cycles counts RUN-state cycles where req_valid is nonzero but no transfer occurs;
  - it clears on cfg_start and saturates at 2^32-1.
- Undefined: no counter logic is built and stall_cycles is tied to 0.

## Test plan
- NUM_REQ=4, cfg_base=0x1000, cfg_lines=2, all req_valid held high, acks returned 3 cycles after each write:
  - 8 writes in grant order 0,1,2,3,0,1,2,3;
  - addresses 0x1000,0x1002,0x1004,0x1006,0x1001,0x1003,0x1005,0x1007;
  - done asserts one cycle after the last ack.
- Only producer 2 valid, cfg_lines=3: three consecutive wr_valid cycles at base+6, base+7, base+8, with mdata 0x0200, 0x0201, 0x0202.
- c1_alm_full high for 5 cycles in RUN with all valid: no req_ready and no wr_valid for those 5 cycles; the grant resumes at the same rr_ptr. With the stats macro, stall_cycles=5.
- MAX_OUT=16, no acks: exactly 16 writes, then req_ready stays 0. One wr_rsp gives exactly one more write. An ack and a transfer in the same cycle leave outstanding at 16.
- cfg_lines=0 start: RUN, then DRAIN, then DONE within 3 cycles with no wr_valid. A second cfg_start during RUN is ignored, and cfg_base stays unchanged.
- reset_n low for 1 cycle mid-RUN with outstanding=5: the next cycle shows the IDLE state with every output at its reset value. A subsequent cfg_start runs a full region with fresh counters.
